// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Lets four byte sources share one UART transmitter that has no busy or done
// output. A requester is picked, its byte is placed on the switch bus (Sw),
// and Send is pulsed for one cycle. The arbiter then waits for a worst-case
// frame time before it accepts the next request.
//
// Build option:
//   TX_PRIORITY_EN  Undefined (default): round-robin arbitration, which
//                   serves source 0 first after reset.
//                   Defined: fixed priority, where source 0 is highest and
//                   source 3 is lowest. Timing and pulses are the same in
//                   both builds.
//
// The wait length is (FRAME_BITS + 1) * BIT_CYCLES + GUARD. The extra bit
// period is there because the transmitter's bit counter runs freely, so its
// start bit can last anywhere from 1 to BIT_CYCLES cycles.

module uart_tx_arbiter #(
    parameter int BIT_CYCLES = 5209,
    parameter int FRAME_BITS = 11,
    parameter int GUARD      = 2
) (
    input  logic        Clock_2br,
    input  logic        Reset,
    input  logic [3:0]  Req,
    input  logic [31:0] Data,
    output logic [3:0]  Grant,
    output logic [3:0]  Done,
    output logic        Busy,
    output logic [7:0]  Sw,
    output logic        Send
);

    localparam int WAIT_CYCLES = (FRAME_BITS + 1) * BIT_CYCLES + GUARD;
    localparam int CNT_W       = $clog2(WAIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Convert a source index into a one-hot pulse vector.
    function automatic logic [3:0] src_onehot(input logic [1:0] src);
        src_onehot = 4'b0001 << src;
    endfunction

`ifdef TX_PRIORITY_EN
    // Fixed priority: the lowest-numbered active request wins. The
    // last-served pointer takes no part in the decision.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic [1:0] last);
        logic [1:0] win;
        win = last & 2'b00;
        for (int k = 3; k >= 0; k--) begin
            win = req[k] ? 2'(k) : win;
        end
        pick_winner = win;
    endfunction
`else
    // Round-robin: search upward from last+1, wrapping modulo 4. The
    // last-served source is checked last of all.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last + 2'd1;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx   = last + 2'(k);
            win   = (!found && req[idx]) ? idx : win;
            found = found | req[idx];
        end
        pick_winner = win;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       ptr_r;
    logic [1:0]       ptr_nxt_s;
    logic [1:0]       win_r;
    logic [1:0]       win_nxt_s;
    logic [1:0]       pick_s;
    logic [3:0]       grant_r;
    logic [3:0]       grant_nxt_s;
    logic [3:0]       done_r;
    logic [3:0]       done_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic [7:0]       sw_r;
    logic [7:0]       sw_nxt_s;
    logic             send_r;
    logic             send_nxt_s;

    assign Grant = grant_r;
    assign Done  = done_r;
    assign Busy  = busy_r;
    assign Sw    = sw_r;
    assign Send  = send_r;

    // Candidate winner; it is used only in IDLE.
    assign pick_s = pick_winner(Req, ptr_r);

    // Next-state and next-output logic for the IDLE/LOAD/WAIT/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        win_nxt_s   = win_r;
        grant_nxt_s = 4'b0000;
        done_nxt_s  = 4'b0000;
        busy_nxt_s  = busy_r;
        sw_nxt_s    = sw_r;
        send_nxt_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (Req != 4'b0000) begin
                    // Data is sampled only here. Later changes to Data
                    // cannot affect the frame that is being sent.
                    win_nxt_s   = pick_s;
                    sw_nxt_s    = Data[{pick_s, 3'b000} +: 8];
                    grant_nxt_s = src_onehot(pick_s);
                    send_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            end

            LOAD: begin
                // Grant and Send are high for this one cycle only.
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = WAIT;
            end

            WAIT: begin
                // Req is ignored here. Sw keeps the captured byte.
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    done_nxt_s  = src_onehot(win_r);
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end

            DONE: begin
                // The served source goes to the back of the round-robin order.
                // Sw keeps the last byte and is not cleared.
                ptr_nxt_s   = win_r;
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end

            default: begin
                cnt_nxt_s   = CNT_ZERO;
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register. A reset ends any frame in progress without a Done pulse.
    always_ff @(posedge Clock_2br or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: the wait counter, the pointer, the winner and all outputs.
    always_ff @(posedge Clock_2br or posedge Reset) begin
        if (Reset) begin
            cnt_r   <= CNT_ZERO;
            ptr_r   <= 2'd3;
            win_r   <= 2'd0;
            grant_r <= 4'b0000;
            done_r  <= 4'b0000;
            busy_r  <= 1'b0;
            sw_r    <= 8'h00;
            send_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            win_r   <= win_nxt_s;
            grant_r <= grant_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
            sw_r    <= sw_nxt_s;
            send_r  <= send_nxt_s;
        end
    end

endmodule
